// File: rtl/ack_bus_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ack_bus_pkg
// Description : Shared constants, state encoding and the priority search
//               helper for the ACK bus scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ack_bus_pkg;

    localparam int NUM_REQ = 4;

    // Requester IDs, lowest ID is highest base priority
    localparam logic [1:0] ID_MEM  = 2'd0;
    localparam logic [1:0] ID_SHA  = 2'd1;
    localparam logic [1:0] ID_AES  = 2'd2;
    localparam logic [1:0] ID_CTRL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // First set bit of vec, searching upward from start and wrapping at NUM_REQ.
    // With start=0 this is a plain lowest-ID priority encoder.
    function automatic logic [1:0] pick_from(input logic [NUM_REQ-1:0] vec,
                                             input logic [1:0]         start);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = start + 2'(i);
            if (!found && vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ack_age_counter.sv
`default_nettype none
// ============================================================================
// Module      : ack_age_counter
// Description : Saturating wait counter for one ACK requester. Counts cycles
//               the request is pending and not being granted; clears on grant
//               or when the request is withdrawn.
// Revision    : 1.0 - initial release
// ============================================================================
module ack_age_counter #(
    parameter int MAX_WAIT = 7,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_i,
    input  logic             grant_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on grant/withdraw, otherwise climb and stick at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || grant_i) begin
            cnt_d = '0;
        end else if (cnt_q != C_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ack_bus_sched.sv
`default_nettype none
// ============================================================================
// Module      : ack_bus_sched
// Description : Scheduler for the shared ACK bus. Picks one of MEM/SHA/AES/
//               CTRL per grant slot, drives a registered one-hot READY pulse,
//               the winner ID and ack_event, then inserts a turnaround gap.
//               Aging counters force priority for requesters that waited
//               MAX_WAIT cycles.
//               Optional macro ACK_BUS_ROUND_ROBIN_EN: rotating base policy
//               starting one past the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
module ack_bus_sched
    import ack_bus_pkg::*;
#(
    parameter int MAX_WAIT   = 7,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_mem,
    input  logic       req_sha,
    input  logic       req_aes,
    input  logic       req_ctrl,
    output logic       ack_ready_to_mem,
    output logic       ack_ready_to_sha,
    output logic       ack_ready_to_aes,
    output logic       ack_ready_to_ctrl,
    output logic [1:0] winner_source_id,
    output logic       ack_event,
    output logic       busy
);

    localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
    localparam int               GAP_W      = 4;
    localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);
    localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    logic [NUM_REQ-1:0]            req_vec;
    logic [NUM_REQ-1:0][CNT_W-1:0] wait_cnt;
    logic [NUM_REQ-1:0]            aged_vec;
    logic [1:0]                    sel_id;
    logic                          grant_fire;
    logic [NUM_REQ-1:0]            grant_vec;

    state_e             state_q,     state_d;
    logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [NUM_REQ-1:0] ready_q,     ready_d;
    logic [1:0]         winner_q,    winner_d;
    logic               ack_event_q, ack_event_d;

    assign req_vec = {req_ctrl, req_aes, req_sha, req_mem};

    // One aging counter per requester; a counter only matters while its request is pending
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
        ack_age_counter #(
            .MAX_WAIT (MAX_WAIT),
            .CNT_W    (CNT_W)
        ) u_age (
            .clk     (clk),
            .rst     (rst),
            .req_i   (req_vec[i]),
            .grant_i (grant_vec[i]),
            .cnt_o   (wait_cnt[i])
        );
        assign aged_vec[i] = req_vec[i] && (wait_cnt[i] == C_MAX_WAIT);
    end

`ifdef ACK_BUS_ROUND_ROBIN_EN
    logic [1:0] rr_ptr_q;

    // Remember the last winner so the next search starts just past it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 2'd0;
        end else if (grant_fire) begin
            rr_ptr_q <= sel_id;
        end
    end

    // Starved requesters first, otherwise rotate from the last winner
    always_comb begin
        if (|aged_vec) begin
            sel_id = pick_from(aged_vec, ID_MEM);
        end else begin
            sel_id = pick_from(req_vec, rr_ptr_q + 2'd1);
        end
    end
`else
    // Starved requesters first, otherwise fixed lowest-ID priority
    always_comb begin
        if (|aged_vec) begin
            sel_id = pick_from(aged_vec, ID_MEM);
        end else begin
            sel_id = pick_from(req_vec, ID_MEM);
        end
    end
`endif

    assign grant_fire = (state_q == ST_IDLE) && (|req_vec);
    assign grant_vec  = grant_fire ? (4'b0001 << sel_id) : '0;

    // FSM next state and registered output values
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        ready_d     = '0;
        ack_event_d = 1'b0;
        winner_d    = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_fire) begin
                    ready_d     = grant_vec;
                    ack_event_d = 1'b1;
                    winner_d    = sel_id;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gap_cnt_d = C_GAP_LOAD;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, gap counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            ready_q     <= '0;
            winner_q    <= ID_MEM;
            ack_event_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            ready_q     <= ready_d;
            winner_q    <= winner_d;
            ack_event_q <= ack_event_d;
        end
    end

    assign ack_ready_to_mem  = ready_q[ID_MEM];
    assign ack_ready_to_sha  = ready_q[ID_SHA];
    assign ack_ready_to_aes  = ready_q[ID_AES];
    assign ack_ready_to_ctrl = ready_q[ID_CTRL];
    assign winner_source_id  = winner_q;
    assign ack_event         = ack_event_q;
    assign busy              = (state_q != ST_IDLE);

    // At most one requester may ever see READY
    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(ready_q));

endmodule
`default_nettype wire
